// File: rtl/dir_input_ctrl_pkg.sv
// Shared game definitions: one-hot directions, PS/2 set-2 scan codes and the
// scan-code decoder state encoding.
package dir_input_ctrl_pkg;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  localparam logic [7:0] SC_EXT         = 8'hE0;
  localparam logic [7:0] SC_BRK         = 8'hF0;
  localparam logic [7:0] SC_UP_ARROW    = 8'h75;
  localparam logic [7:0] SC_DOWN_ARROW  = 8'h72;
  localparam logic [7:0] SC_LEFT_ARROW  = 8'h6B;
  localparam logic [7:0] SC_RIGHT_ARROW = 8'h74;
  localparam logic [7:0] SC_W           = 8'h1D;
  localparam logic [7:0] SC_S           = 8'h1B;
  localparam logic [7:0] SC_A           = 8'h1C;
  localparam logic [7:0] SC_D           = 8'h23;
  localparam logic [7:0] SC_ENTER       = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  // Swaps up<->down and left<->right within the one-hot code.
  function automatic logic [3:0] opposite_dir(input logic [3:0] dir);
    return {dir[2], dir[3], dir[0], dir[1]};
  endfunction

endpackage

// File: rtl/dir_input_ctrl_turn_fifo.sv
// Pending-turn queue: synchronous circular buffer of one-hot directions with
// head/tail read ports. Pop is applied before push, so a full queue accepts a
// push in the same cycle as a pop.
module turn_fifo
  import dir_input_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] push_dir,
  output logic [3:0] head,
  output logic [3:0] tail,
  output logic [2:0] count
);

  localparam logic [1:0] LAST_PTR = 2'(DEPTH - 1);
  localparam logic [2:0] DEPTH_C  = 3'(DEPTH);

  logic [3:0] r_mem [0:3];
  logic [1:0] r_rd_ptr;
  logic [1:0] r_wr_ptr;
  logic [2:0] r_count;
  logic       w_pop;
  logic       w_push;
  logic [1:0] w_tail_ptr;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

  // Qualify requests and locate the most recently written entry.
  always_comb begin
    w_pop  = pop && (r_count != 3'd0);
    w_push = push && ((r_count < DEPTH_C) || w_pop);
    if (r_wr_ptr == 2'd0) begin
      w_tail_ptr = LAST_PTR;
    end else begin
      w_tail_ptr = r_wr_ptr - 2'd1;
    end
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_mem[i] <= 4'b0000;
      end
      r_rd_ptr <= 2'd0;
      r_wr_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_dir;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign tail  = r_mem[w_tail_ptr];
  assign count = r_count;

endmodule

// File: rtl/dir_input_ctrl.sv
// PS/2 keyboard direction input: decodes set-2 make codes into one-hot turns,
// filters repeats and reversals, and queues turns until the game steps.
module dir_input_ctrl
  import dir_input_ctrl_pkg::*;
#(
  parameter int         QDEPTH    = 2,
  parameter logic [3:0] RESET_DIR = 4'b0001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       step,
  output logic [3:0] key,
  output logic [2:0] pending,
  output logic       restart
);

  localparam logic [2:0] DEPTH_C = 3'(QDEPTH);

  dec_state_t r_state;
  logic [3:0] r_key;
  logic       r_restart;

  logic       w_dec_valid;
  logic [3:0] w_dec_dir;
  logic [3:0] w_ref;
  logic [3:0] w_head;
  logic [3:0] w_tail;
  logic [2:0] w_count;
  logic       w_accept;
  logic       w_pop;
  logic       w_push;

  // Make-code decode for the byte arriving this cycle.
  always_comb begin
    w_dec_valid = 1'b0;
    w_dec_dir   = 4'b0000;
    if (rx_valid && (r_state == ST_IDLE)) begin
      case (rx_byte)
        SC_W:    begin w_dec_valid = 1'b1; w_dec_dir = DIR_UP;    end
        SC_S:    begin w_dec_valid = 1'b1; w_dec_dir = DIR_DOWN;  end
        SC_A:    begin w_dec_valid = 1'b1; w_dec_dir = DIR_LEFT;  end
        SC_D:    begin w_dec_valid = 1'b1; w_dec_dir = DIR_RIGHT; end
        default: begin w_dec_valid = 1'b0; w_dec_dir = 4'b0000;   end
      endcase
    end else if (rx_valid && (r_state == ST_EXT)) begin
      case (rx_byte)
        SC_UP_ARROW:    begin w_dec_valid = 1'b1; w_dec_dir = DIR_UP;    end
        SC_DOWN_ARROW:  begin w_dec_valid = 1'b1; w_dec_dir = DIR_DOWN;  end
        SC_LEFT_ARROW:  begin w_dec_valid = 1'b1; w_dec_dir = DIR_LEFT;  end
        SC_RIGHT_ARROW: begin w_dec_valid = 1'b1; w_dec_dir = DIR_RIGHT; end
        default:        begin w_dec_valid = 1'b0; w_dec_dir = 4'b0000;   end
      endcase
    end else begin
      w_dec_valid = 1'b0;
      w_dec_dir   = 4'b0000;
    end
  end

  // Reference is the last turn the snake will take: the queued tail if any.
  always_comb begin
    w_ref = r_key;
    if (w_count != 3'd0) begin
      w_ref = w_tail;
    end else begin
      w_ref = r_key;
    end
  end

  assign w_accept = w_dec_valid && (w_dec_dir != w_ref) &&
                    (w_dec_dir != opposite_dir(w_ref));
  assign w_pop    = step && (w_count != 3'd0);
  assign w_push   = w_accept && ((w_count < DEPTH_C) || w_pop);

  turn_fifo #(
    .DEPTH(QDEPTH)
  ) u_turn_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .pop     (w_pop),
    .push_dir(w_dec_dir),
    .head    (w_head),
    .tail    (w_tail),
    .count   (w_count)
  );

  // Decoder FSM with registered key and restart outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_key     <= RESET_DIR;
      r_restart <= 1'b0;
    end else begin
      r_restart <= 1'b0;
      if (w_pop) begin
        r_key <= w_head;
      end
      if (rx_valid) begin
        case (r_state)
          ST_IDLE: begin
            case (rx_byte)
              SC_EXT:   r_state <= ST_EXT;
              SC_BRK:   r_state <= ST_BRK;
              SC_ENTER: begin
                r_state   <= ST_IDLE;
                r_restart <= 1'b1;
              end
              default:  r_state <= ST_IDLE;
            endcase
          end
          ST_EXT: begin
            if (rx_byte == SC_BRK) begin
              r_state <= ST_EXT_BRK;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign key     = r_key;
  assign pending = w_count;
  assign restart = r_restart;

endmodule

// File: tb/tb_dir_input_ctrl.sv
// Directed, table-driven bench for dir_input_ctrl (QDEPTH=2, RESET_DIR=0001).
module tb_dir_input_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       step;
  logic [3:0] key;
  logic [2:0] pending;
  logic       restart;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] byt;
    logic       stp;
    logic [3:0] exp_key;
    logic [2:0] exp_pend;
    logic       exp_rs;
  } vec_t;

  vec_t vecs[$];

  dir_input_ctrl #(
    .QDEPTH   (2),
    .RESET_DIR(4'b0001)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .step    (step),
    .key     (key),
    .pending (pending),
    .restart (restart)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic v, input logic [7:0] b,
                              input logic s, input logic [3:0] k,
                              input logic [2:0] p, input logic rs);
    vec_t t;
    t.rst = r; t.vld = v; t.byt = b; t.stp = s;
    t.exp_key = k; t.exp_pend = p; t.exp_rs = rs;
    vecs.push_back(t);
  endfunction

  // Drive one cycle of inputs, then check all outputs just after the edge.
  task automatic apply(input string name, input logic r, input logic v,
                       input logic [7:0] b, input logic s, input logic [3:0] k,
                       input logic [2:0] p, input logic rs);
    @(negedge clk);
    rst = r; rx_valid = v; rx_byte = b; step = s;
    @(posedge clk);
    #1;
    n_cmp++;
    if (key !== k || pending !== p || restart !== rs) begin
      n_bad++;
      $display("FAIL %s: got key=%b pending=%0d restart=%b, want key=%b pending=%0d restart=%b",
               name, key, pending, restart, k, p, rs);
    end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; step = 1'b0;
    n_cmp = 0; n_bad = 0;

    //   rst   vld   byte   stp   key      pend  rs
    add(1'b1, 1'b0, 8'h00, 1'b0, 4'b0001, 3'd0, 1'b0); // reset state
    add(1'b1, 1'b1, 8'h1C, 1'b1, 4'b0001, 3'd0, 1'b0); // rst beats rx/step
    // E0 74, step
    add(1'b0, 1'b1, 8'hE0, 1'b0, 4'b0001, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'h74, 1'b0, 4'b0001, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 4'b1000, 3'd0, 1'b0);
    // reset, S reversal dropped, step holds key
    add(1'b1, 1'b0, 8'h00, 1'b0, 4'b0001, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'h1B, 1'b0, 4'b0001, 3'd0, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 4'b0001, 3'd0, 1'b0);
    // A, W fill queue; D dropped while full; two steps
    add(1'b0, 1'b1, 8'h1C, 1'b0, 4'b0001, 3'd1, 1'b0);
    add(1'b0, 1'b1, 8'h1D, 1'b0, 4'b0001, 3'd2, 1'b0);
    add(1'b0, 1'b1, 8'h23, 1'b0, 4'b0001, 3'd2, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 4'b0100, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 4'b0001, 3'd0, 1'b0);
    // E0 F0 6B, F0 1C discarded; next 1C accepted
    add(1'b0, 1'b1, 8'hE0, 1'b0, 4'b0001, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'hF0, 1'b0, 4'b0001, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'h6B, 1'b0, 4'b0001, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'hF0, 1'b0, 4'b0001, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'h1C, 1'b0, 4'b0001, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'h1C, 1'b0, 4'b0001, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 4'b0100, 3'd0, 1'b0);
    // full [L,U], step with D: pop then push, tail becomes R
    add(1'b1, 1'b0, 8'h00, 1'b0, 4'b0001, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'h1C, 1'b0, 4'b0001, 3'd1, 1'b0);
    add(1'b0, 1'b1, 8'h1D, 1'b0, 4'b0001, 3'd2, 1'b0);
    add(1'b0, 1'b1, 8'h23, 1'b1, 4'b0100, 3'd2, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 4'b0001, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 4'b1000, 3'd0, 1'b0);
    // repeat and reversal of R dropped, W accepted
    add(1'b0, 1'b1, 8'h23, 1'b0, 4'b1000, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'h1C, 1'b0, 4'b1000, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'h1D, 1'b0, 4'b1000, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 4'b0001, 3'd0, 1'b0);
    // step with push at pending=0: key holds, entry waits
    add(1'b0, 1'b1, 8'h1C, 1'b1, 4'b0001, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 4'b0100, 3'd0, 1'b0);
    // unknown byte, non-code after E0, extended arrows
    add(1'b0, 1'b1, 8'h15, 1'b0, 4'b0100, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'hE0, 1'b0, 4'b0100, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'h1D, 1'b0, 4'b0100, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'hE0, 1'b0, 4'b0100, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'h6B, 1'b0, 4'b0100, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'hE0, 1'b0, 4'b0100, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'h75, 1'b0, 4'b0100, 3'd1, 1'b0);
    // restart does not touch queue or key
    add(1'b0, 1'b1, 8'h5A, 1'b0, 4'b0100, 3'd1, 1'b1);
    add(1'b0, 1'b0, 8'h00, 1'b0, 4'b0100, 3'd1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 4'b0001, 3'd0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("vec%0d", i), vecs[i].rst, vecs[i].vld, vecs[i].byt,
            vecs[i].stp, vecs[i].exp_key, vecs[i].exp_pend, vecs[i].exp_rs);
    end

    // Reset mid-sequence discards the pending E0 prefix.
    apply("mid_e0",    1'b0, 1'b1, 8'hE0, 1'b0, 4'b0001, 3'd0, 1'b0);
    apply("mid_rst",   1'b1, 1'b0, 8'h00, 1'b0, 4'b0001, 3'd0, 1'b0);
    apply("post_75",   1'b0, 1'b1, 8'h75, 1'b0, 4'b0001, 3'd0, 1'b0);
    apply("post_w",    1'b0, 1'b1, 8'h1D, 1'b0, 4'b0001, 3'd0, 1'b0);
    apply("enter",     1'b0, 1'b1, 8'h5A, 1'b0, 4'b0001, 3'd0, 1'b1);
    apply("enter_end", 1'b0, 1'b0, 8'h00, 1'b0, 4'b0001, 3'd0, 1'b0);

    // Break of Enter must not pulse restart.
    apply("brk_f0",    1'b0, 1'b1, 8'hF0, 1'b0, 4'b0001, 3'd0, 1'b0);
    apply("brk_5a",    1'b0, 1'b1, 8'h5A, 1'b0, 4'b0001, 3'd0, 1'b0);
    apply("brk_idle",  1'b0, 1'b0, 8'h00, 1'b0, 4'b0001, 3'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
